keypad_scanner: RTL

- Scans a 4x4 matrix keypad (Pmod KYPD style) and produces a debounced 4-bit hex key code.
- Input-side counterpart of the multiplexed seven-segment output path: it drives column strobes one at a time, reads the row lines, debounces and reports key presses.
- Its output feeds the stopwatch control/display logic (key code and valid pulse).

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_scanner_scan_timer.sv | 36 +++
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key-code table for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_e;

  typedef struct packed {
    scan_res_e  res;
    logic [3:0] code;
  } scan_t;

  // Indexed by {row, col}; row 0 is the top row, col 0 the leftmost column.
  localparam logic [15:0][3:0] CODE_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/keypad_scanner_scan_timer.sv
// Column strobe timing: holds each column for SCAN_TICKS cycles and flags the
// row-sample cycle and the end of a full four-column scan.
module scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [NUM_COLS-1:0] col,
  output logic [1:0]          col_idx,
  output logic                sample_strobe,
  output logic                scan_end
);

  localparam int TW = $clog2(SCAN_TICKS);

  logic [TW-1:0] tick;

  assign sample_strobe = (tick == TW'(SCAN_TICKS - 1));
  assign scan_end      = sample_strobe && (col_idx == 2'd3);
  assign col           = ~(NUM_COLS'(1) << col_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick    <= '0;
      col_idx <= '0;
    end else if (sample_strobe) begin
      tick    <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      tick    <= tick + TW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, classifies each full scan and
// debounces press/release into a hex key code with a one-cycle valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [1:0]    col_idx;
  logic          sample_strobe, scan_end;
  logic [3:0]    row_s1, row_s2, low;
  logic [1:0]    hits_q, hits_d, frow;
  logic [2:0]    nlow, hit_sum;
  logic [3:0]    code_q, code_d;
  scan_t         scan;

  kp_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d, key_q, key_d;
  logic          kdown_q, kdown_d, kvalid_q, kvalid_d;

  scan_timer #(.SCAN_TICKS(SCAN_TICKS)) u_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .col           (col),
    .col_idx       (col_idx),
    .sample_strobe (sample_strobe),
    .scan_end      (scan_end)
  );

  // Idle rows read high, so the synchronizer resets to "no key".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign low = ~row_s2;

  // Hit count saturates at 2: only "none / one / more" matters.
  always_comb begin
    nlow = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    frow = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--)
      if (low[r]) frow = 2'(r);
    hit_sum = {1'b0, hits_q} + nlow;
    hits_d  = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    code_d  = code_q;
    if (hits_q == 2'd0 && nlow == 3'd1)
      code_d = CODE_MAP[{frow, col_idx}];
    scan.code = code_d;
    scan.res  = (hits_d == 2'd0) ? NONE : (hits_d == 2'd1) ? SINGLE : MULTI;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits_q <= '0;
      code_q <= '0;
    end else if (scan_end) begin
      hits_q <= '0;
      code_q <= '0;
    end else if (sample_strobe) begin
      hits_q <= hits_d;
      code_q <= code_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      key_q    <= '0;
      kdown_q  <= 1'b0;
      kvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      key_q    <= key_d;
      kdown_q  <= kdown_d;
      kvalid_q <= kvalid_d;
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    key_d    = key_q;
    kdown_d  = kdown_q;
    kvalid_d = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        IDLE: if (scan.res == SINGLE) begin
          cand_d = scan.code;
          cnt_d  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            key_d    = scan.code;
            kvalid_d = 1'b1;
            kdown_d  = 1'b1;
            state_d  = PRESSED;
          end else begin
            state_d  = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (scan.res == SINGLE && scan.code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              key_d    = cand_q;
              kvalid_d = 1'b1;
              kdown_d  = 1'b1;
              state_d  = PRESSED;
            end
          end else if (scan.res == SINGLE) begin
            cand_d = scan.code;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        // Rollover and extra keys are ignored while a key is held.
        PRESSED: if (scan.res == NONE) begin
          cnt_d = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            kdown_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (scan.res == NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              kdown_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign key       = key_q;
  assign key_valid = kvalid_q;
  assign key_down  = kdown_q;

endmodule
